// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
// It holds the FSM state codes and the rotating-priority pick helper.
package arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Returns the first set request bit, scanning ptr, ptr+1, ... mod n.
    // The scan is sized for the largest supported arbiter, which has 16 requesters.
    // It returns 0 when no request is set, and callers only use it when |req.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) begin
                    found = 1'b1;
                    pick  = idx[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb_onehot_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arb_onehot_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          gnt_vld;
    logic          preempt;

    // Requester side: drives enable and requests, and observes grants.
    modport master (output en, output req,
                    input gnt, input gnt_id, input gnt_vld, input preempt);

    // Arbiter side.
    modport slave  (input en, input req,
                    output gnt, output gnt_id, output gnt_vld, output preempt);
endinterface

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with an output enable: y = en ? (1 << d) : 0.
module onehot_dec #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [IW-1:0] d,
    input  logic          en,
    output logic [N-1:0]  y
);

    // Decode d into a single hot bit, forced to zero when en is low.
    always_comb begin
        // NOTE: y gets a default first, so every path assigns it and no latch is inferred.
        y = '0;
        if (en) begin
            y[d] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter with a hold limit. The registered binary winner is
// decoded into a one-hot grant. Every release or preemption leaves one idle
// cycle, so consecutive owners never overlap.
module rr_arb_onehot
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int HOLD_MAX = 8,
    parameter int CW       = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_arb_onehot_if.slave bus
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] hold_cnt;
    logic [IW-1:0] gnt_id_q;
    logic          gnt_vld_q;
    logic          preempt_q;
    logic [IW-1:0] winner;
    logic          owner_req;

    // Rotating-priority winner among the live requests, and the current owner's request.
    always_comb begin
        winner    = IW'(rr_pick(16'(bus.req), 4'(ptr), N));
        owner_req = bus.req[gnt_id_q];
    end

    // Grant FSM: an idle cycle picks a winner, and the grant ends on release or timeout.
    always_ff @(posedge clk) begin
        // NOTE: all state here updates with non-blocking assignments, so every read sees pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    preempt_q <= 1'b0;
                    if (bus.en && |bus.req) begin
                        gnt_id_q  <= winner;
                        gnt_vld_q <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                    if (!owner_req) begin
                        // A release also wins over a timeout in the same cycle, so no preempt pulse.
                        state     <= ST_IDLE;
                        gnt_vld_q <= 1'b0;
                        ptr       <= gnt_id_q + IW'(1);
                        preempt_q <= 1'b0;
                    end else if (HOLD_MAX != 0 && hold_cnt == HOLD_LAST) begin
                        state     <= ST_IDLE;
                        gnt_vld_q <= 1'b0;
                        ptr       <= gnt_id_q + IW'(1);
                        preempt_q <= 1'b1;
                    end else begin
                        preempt_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.preempt = preempt_q;

    onehot_dec #(.N(N), .IW(IW)) u_dec (
        .d  (gnt_id_q),
        .en (gnt_vld_q),
        .y  (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arb_onehot.sv
// Self-checking bench for rr_arb_onehot. A behavioural model tracks the
// owner and how long it has held the grant, and it queues the expected outputs.
// A monitor on the falling edge pops each expectation and compares it.
module tb_rr_arb_onehot;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int HOLD_MAX = 8;
    localparam int CW       = 4;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] gnt_id;
        logic          gnt_vld;
        logic          preempt;
    } exp_t;

    logic clk;
    logic rst;

    rr_arb_onehot_if #(.N(N), .IW(IW)) bus ();

    rr_arb_onehot #(.N(N), .IW(IW), .HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state: -1 means nobody owns the resource.
    int m_owner = -1;
    int m_last  = 0;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_pre   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: apply the arbitration rules to the inputs seen at this edge.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_owner = -1; m_last = 0; m_held = 0; m_ptr = 0; m_pre = 1'b0;
        end else if (m_owner < 0) begin
            m_pre = 1'b0;
            if (bus.en && bus.req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (bus.req[c] && m_owner < 0) begin
                        m_owner = c;
                        m_last  = c;
                        m_held  = 1;
                    end
                end
            end
        end else if (!bus.req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_pre   = 1'b0;
        end else if (HOLD_MAX != 0 && m_held == HOLD_MAX) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_pre   = 1'b1;
        end else begin
            m_held++;
            m_pre = 1'b0;
        end
        e.gnt     = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.gnt_id  = IW'(m_last);
        e.gnt_vld = (m_owner >= 0);
        e.preempt = m_pre;
        exp_q.push_back(e);
    end

    // Monitor: compare the settled outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt",     32'(bus.gnt),     32'(e.gnt));
            check("gnt_id",  32'(bus.gnt_id),  32'(e.gnt_id));
            check("gnt_vld", 32'(bus.gnt_vld), 32'(e.gnt_vld));
            check("preempt", 32'(bus.preempt), 32'(e.preempt));
            check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        step(2);
        rst = 1'b0;

        // Rotation: each owner drops its request one cycle after its grant appears.
        for (int i = 0; i < 12; i++) begin
            bus.req = 4'b1111;
            if (m_owner >= 0) bus.req[m_owner] = 1'b0;
            step(1);
        end
        bus.req = '0;
        step(2);

        // Timeout with a lone requester, then two requesters alternating under timeout.
        bus.req = 4'b0100;
        step(22);
        bus.req = 4'b0101;
        step(40);
        bus.req = '0;
        step(2);

        // en gates only new grants.
        bus.en  = 1'b0;
        bus.req = 4'b1000;
        step(3);
        bus.en = 1'b1;
        step(2);
        bus.en = 1'b0;
        step(3);
        bus.req = '0;
        step(2);
        bus.en = 1'b1;

        // Reset in the middle of a grant to requester 1, then a fresh pick from pointer 0.
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        bus.req = 4'b0010;
        step(3);
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        bus.req = 4'b1010;
        step(4);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            bus.req = 4'($urandom);
            bus.en  = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 63) == 0);
            step(1);
        end
        rst = 1'b0;
        step(1);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
